// File: rtl/sys_bridge_n_pkg.sv
// Shared definitions for the parametrised CPU-to-peripheral bridge:
// FSM state encoding and the default DM/Timer0/Timer1 address windows.
package sys_bridge_n_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] DM_BASE    = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT   = 32'h0000_2FFF;
  localparam logic [31:0] TMR0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TMR0_LIMIT = 32'h0000_7F0B;
  localparam logic [31:0] TMR1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] TMR1_LIMIT = 32'h0000_7F1B;

  localparam int DEF_NSLV = 3;

  // Slave 0 occupies the least-significant slice of the packed vectors.
  localparam logic [DEF_NSLV*32-1:0] DEF_SLV_BASE  = {TMR1_BASE, TMR0_BASE, DM_BASE};
  localparam logic [DEF_NSLV*32-1:0] DEF_SLV_LIMIT = {TMR1_LIMIT, TMR0_LIMIT, DM_LIMIT};

endpackage

// File: rtl/sys_bridge_n_addr_decode.sv
// Combinational address window decoder: one-hot select of the lowest-index
// slave whose inclusive [base, limit] window contains addr.
module addr_decode_n
  import sys_bridge_n_pkg::*;
#(
  parameter int                 NSLV      = DEF_NSLV,
  parameter logic [NSLV*32-1:0] SLV_BASE  = DEF_SLV_BASE,
  parameter logic [NSLV*32-1:0] SLV_LIMIT = DEF_SLV_LIMIT
) (
  input  logic [31:0]     addr,
  output logic            hit,
  output logic [NSLV-1:0] sel
);

  // Once a window has matched, higher indices are masked out.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (!hit && (addr >= SLV_BASE[i*32 +: 32]) && (addr <= SLV_LIMIT[i*32 +: 32])) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: decodes the CPU access, registers it towards the
// selected slave, waits for its ready (bounded) and reports data or bus error.
module sys_bridge_n
  import sys_bridge_n_pkg::*;
#(
  parameter int                 NSLV      = DEF_NSLV,
  parameter logic [NSLV*32-1:0] SLV_BASE  = DEF_SLV_BASE,
  parameter logic [NSLV*32-1:0] SLV_LIMIT = DEF_SLV_LIMIT,
  parameter int                 TIMEOUT   = 16,
  parameter int                 TCW       = $clog2(TIMEOUT) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           byteen,
  output logic                 busy,
  output logic                 rvalid,
  output logic [31:0]          rdata,
  output logic                 bus_err,
  output logic [31:0]          err_addr,
  output logic [NSLV-1:0]      sl_sel,
  output logic [31:0]          sl_addr,
  output logic [31:0]          sl_wdata,
  output logic [NSLV*4-1:0]    sl_byteen,
  input  logic [NSLV*32-1:0]   sl_rdata,
  input  logic [NSLV-1:0]      sl_ready,
  input  logic [NSLV-1:0]      irq_in,
  output logic [NSLV-1:0]      hwint
);

  state_e          state_q, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      byteen_q, byteen_d;
  logic [TCW-1:0]  cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic [NSLV-1:0] hwint_q, hwint_d;

  logic            dec_hit;
  logic [NSLV-1:0] dec_sel;
  logic            sel_ready;
  logic [31:0]     sel_rdata;

  addr_decode_n #(
    .NSLV      (NSLV),
    .SLV_BASE  (SLV_BASE),
    .SLV_LIMIT (SLV_LIMIT)
  ) u_addr_decode (
    .addr (addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // sel_q is one-hot, so an OR-mux picks the active slave's read data.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | sl_rdata[i*32 +: 32];
    end
  end

  assign sel_ready = |(sl_ready & sel_q);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byteen_d   = byteen_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    hwint_d    = irq_in;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_hit) begin
            addr_d   = addr;
            wdata_d  = wdata;
            byteen_d = byteen;
            sel_d    = dec_sel;
            cnt_d    = '0;
            state_d  = ACCESS;
          end else begin
            err_addr_d = addr;
            bus_err_d  = 1'b1;
            rdata_d    = '0;
            state_d    = RESP;
          end
        end
      end
      ACCESS: begin
        // Ready on the final allowed cycle still wins over the timeout.
        if (sel_ready) begin
          rdata_d   = sel_rdata;
          bus_err_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == TCW'(TIMEOUT - 1)) begin
          err_addr_d = addr_q;
          bus_err_d  = 1'b1;
          rdata_d    = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      byteen_q   <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
      hwint_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byteen_q   <= byteen_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
      hwint_q    <= hwint_d;
    end
  end

  always_comb begin
    sl_sel    = '0;
    sl_byteen = '0;
    if (state_q == ACCESS) begin
      sl_sel = sel_q;
      for (int i = 0; i < NSLV; i++) begin
        if (sel_q[i]) sl_byteen[i*4 +: 4] = byteen_q;
      end
    end
  end

  assign busy     = (state_q == ACCESS) || (state_q == RESP);
  assign rvalid   = (state_q == RESP);
  assign rdata    = rdata_q;
  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
  assign sl_addr  = addr_q;
  assign sl_wdata = wdata_q;
  assign hwint    = hwint_q;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Self-checking bench for sys_bridge_n: directed vector table, hand-written
// corner sequences, and randomized accesses checked against a window model.
module tb_sys_bridge_n;

  localparam int NSLV    = 3;
  localparam int TIMEOUT = 16;

  logic             clk;
  logic             reset_n;
  logic             req;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [3:0]       byteen;
  logic             busy;
  logic             rvalid;
  logic [31:0]      rdata;
  logic             bus_err;
  logic [31:0]      err_addr;
  logic [NSLV-1:0]  sl_sel;
  logic [31:0]      sl_addr;
  logic [31:0]      sl_wdata;
  logic [NSLV*4-1:0]  sl_byteen;
  logic [NSLV*32-1:0] sl_rdata;
  logic [NSLV-1:0]  sl_ready;
  logic [NSLV-1:0]  irq_in;
  logic [NSLV-1:0]  hwint;

  sys_bridge_n #(
    .NSLV    (NSLV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .byteen    (byteen),
    .busy      (busy),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .bus_err   (bus_err),
    .err_addr  (err_addr),
    .sl_sel    (sl_sel),
    .sl_addr   (sl_addr),
    .sl_wdata  (sl_wdata),
    .sl_byteen (sl_byteen),
    .sl_rdata  (sl_rdata),
    .sl_ready  (sl_ready),
    .irq_in    (irq_in),
    .hwint     (hwint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    int          tgt;
    int          ready_at;
    logic [31:0] srdata;
    logic [2:0]  exp_sel;
    logic [11:0] exp_be;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [31:0] exp_err_addr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [2:0]  obs_sel;
  logic [11:0] obs_be;
  logic [31:0] obs_saddr;
  logic [31:0] obs_swdata;
  int          obs_lat;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [31:0] obs_err_addr;

  logic [31:0] win_base  [NSLV] = '{32'h0000, 32'h7F00, 32'h7F10};
  logic [31:0] win_limit [NSLV] = '{32'h2FFF, 32'h7F0B, 32'h7F1B};
  logic [31:0] model_err_addr;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Issues one CPU access, plays the slave side and records what came back.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                               input int tgt, input int ready_at, input logic [31:0] srd);
    int  c;
    bit  done;
    @(negedge clk);
    req    = 1'b1;
    addr   = a;
    wdata  = wd;
    byteen = be;
    for (int i = 0; i < NSLV; i++) sl_rdata[i*32 +: 32] = $urandom;
    if (tgt >= 0) sl_rdata[tgt*32 +: 32] = srd;
    sl_ready = 3'($urandom);
    if (tgt >= 0) sl_ready[tgt] = 1'b0;
    obs_lat = -1;
    c = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        obs_sel    = sl_sel;
        obs_be     = sl_byteen;
        obs_saddr  = sl_addr;
        obs_swdata = sl_wdata;
      end
      if (rvalid) begin
        obs_lat      = c;
        obs_rdata    = rdata;
        obs_err      = bus_err;
        obs_err_addr = err_addr;
        checkOutput("resp_busy", 32'(busy), 32'd1);
        checkOutput("resp_sel", 32'(sl_sel), 32'd0);
        req      = 1'b0;
        sl_ready = '0;
        done     = 1'b1;
      end else begin
        checkOutput("access_busy", 32'(busy), 32'd1);
        sl_ready = 3'($urandom);
        if (tgt >= 0) sl_ready[tgt] = (c == ready_at);
      end
    end
    req = 1'b0;
    if (done) begin
      @(negedge clk);
      checkOutput("rvalid_single", 32'(rvalid), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic runVector(input string nm, input vec_t v);
    applyStimulus(v.addr, v.wdata, v.byteen, v.tgt, v.ready_at, v.srdata);
    checkOutput({nm, "_lat"}, 32'(obs_lat), 32'(v.exp_lat));
    checkOutput({nm, "_sel"}, 32'(obs_sel), 32'(v.exp_sel));
    checkOutput({nm, "_be"}, 32'(obs_be), 32'(v.exp_be));
    checkOutput({nm, "_err"}, 32'(obs_err), 32'(v.exp_err));
    checkOutput({nm, "_rdata"}, obs_rdata, v.exp_rdata);
    checkOutput({nm, "_erraddr"}, obs_err_addr, v.exp_err_addr);
    if (v.tgt >= 0) begin
      checkOutput({nm, "_sladdr"}, obs_saddr, v.addr);
      checkOutput({nm, "_slwdata"}, obs_swdata, v.wdata);
    end
  endtask

  function automatic int modelTarget(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++)
      if (a >= win_base[i] && a <= win_limit[i]) return i;
    return -1;
  endfunction

  // Builds the expected record from window rules and the wait budget alone.
  function automatic vec_t modelVector(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                                       input int ready_at, input logic [31:0] srd);
    vec_t v;
    v.addr = a; v.wdata = wd; v.byteen = be; v.ready_at = ready_at; v.srdata = srd;
    v.tgt = modelTarget(a);
    if (v.tgt < 0) begin
      v.exp_sel = '0; v.exp_be = '0; v.exp_err = 1'b1; v.exp_rdata = '0; v.exp_lat = 1;
      model_err_addr = a;
    end else begin
      v.exp_sel = 3'(1 << v.tgt);
      v.exp_be  = 12'(be) << (4 * v.tgt);
      if (ready_at >= 1 && ready_at <= TIMEOUT) begin
        v.exp_err = 1'b0; v.exp_rdata = srd; v.exp_lat = ready_at + 1;
      end else begin
        v.exp_err = 1'b1; v.exp_rdata = '0; v.exp_lat = TIMEOUT + 1;
        model_err_addr = a;
      end
    end
    v.exp_err_addr = model_err_addr;
    return v;
  endfunction

  vec_t vecs [10];

  initial begin
    int rv_count;
    int first_c;
    vec_t rv;
    logic [31:0] ra;

    vecs[0] = '{32'h0100, 32'h0,        4'b0000,  0,  1, 32'hDEADBEEF, 3'b001, 12'h000, 1'b0, 32'hDEADBEEF,  2, 32'h0};
    vecs[1] = '{32'h7F04, 32'h12345678, 4'b0010,  1,  1, 32'hCAFE0000, 3'b010, 12'h020, 1'b0, 32'hCAFE0000,  2, 32'h0};
    vecs[2] = '{32'h4000, 32'h0,        4'b0000, -1,  1, 32'h0,        3'b000, 12'h000, 1'b1, 32'h0,          1, 32'h4000};
    vecs[3] = '{32'h7F10, 32'h0,        4'b0000,  2, -1, 32'h77777777, 3'b100, 12'h000, 1'b1, 32'h0,         17, 32'h7F10};
    vecs[4] = '{32'h7F1B, 32'h0,        4'b0000,  2,  3, 32'h00000011, 3'b100, 12'h000, 1'b0, 32'h00000011,  4, 32'h7F10};
    vecs[5] = '{32'h2FFF, 32'h99000000, 4'b1000,  0, 16, 32'h00000022, 3'b001, 12'h008, 1'b0, 32'h00000022, 17, 32'h7F10};
    vecs[6] = '{32'h3000, 32'h0,        4'b0000, -1,  1, 32'h0,        3'b000, 12'h000, 1'b1, 32'h0,          1, 32'h3000};
    vecs[7] = '{32'h7F0C, 32'h0,        4'b0001, -1,  1, 32'h0,        3'b000, 12'h000, 1'b1, 32'h0,          1, 32'h7F0C};
    vecs[8] = '{32'h7F1C, 32'h0,        4'b0000, -1,  1, 32'h0,        3'b000, 12'h000, 1'b1, 32'h0,          1, 32'h7F1C};
    vecs[9] = '{32'h7F00, 32'hFFFF0000, 4'b1111,  1,  2, 32'h0BADF00D, 3'b010, 12'h0F0, 1'b0, 32'h0BADF00D,  3, 32'h7F1C};

    reset_n = 1'b0; req = 1'b0; addr = '0; wdata = '0; byteen = '0;
    sl_rdata = '0; sl_ready = '0; irq_in = 3'b101;
    #13;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_err", 32'(bus_err), 32'd0);
    checkOutput("rst_sel", 32'(sl_sel), 32'd0);
    checkOutput("rst_hwint", 32'(hwint), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    irq_in  = '0;

    for (int i = 0; i < 10; i++) runVector($sformatf("vec%0d", i), vecs[i]);

    // Wait states with req toggled while stalled: exactly one response.
    @(negedge clk);
    req = 1'b1; addr = 32'h7F08; byteen = 4'b0000; wdata = 32'h0;
    sl_ready = '0; sl_rdata = '0; sl_rdata[63:32] = 32'h00000055;
    rv_count = 0; first_c = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rvalid) begin
        rv_count++;
        if (first_c < 0) begin
          first_c = c;
          checkOutput("ws_rdata", rdata, 32'h55);
        end
      end
      req = (c < 4) ? ((c % 2) == 1) : 1'b0;
      sl_ready = '0;
      sl_ready[1] = (c == 3);
    end
    checkOutput("ws_count", 32'(rv_count), 32'd1);
    checkOutput("ws_lat", 32'(first_c), 32'd4);

    // Reset in the middle of an access abandons it.
    @(negedge clk);
    irq_in = 3'b011;
    req = 1'b1; addr = 32'h0100; byteen = 4'hF; wdata = 32'hA5A5A5A5; sl_ready = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    checkOutput("mid_hwint", 32'(hwint), 32'd3);
    #2;
    reset_n = 1'b0;
    req = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("arst_rdata", rdata, 32'd0);
    checkOutput("arst_err", 32'(bus_err), 32'd0);
    checkOutput("arst_erraddr", err_addr, 32'd0);
    checkOutput("arst_sel", 32'(sl_sel), 32'd0);
    checkOutput("arst_sladdr", sl_addr, 32'd0);
    checkOutput("arst_slwdata", sl_wdata, 32'd0);
    checkOutput("arst_be", 32'(sl_byteen), 32'd0);
    checkOutput("arst_hwint", 32'(hwint), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sl_ready = '1;
    rv_count = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rvalid) rv_count++;
    end
    checkOutput("arst_no_rvalid", 32'(rv_count), 32'd0);
    sl_ready = '0;

    // hwint is a plain one-cycle register of irq_in.
    irq_in = 3'b100;
    #1;
    checkOutput("irq_before_edge", 32'(hwint), 32'd3);
    @(negedge clk);
    checkOutput("irq_after_edge", 32'(hwint), 32'd4);

    model_err_addr = 32'h0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       ra = 32'($urandom_range(0, 32'h2FFF));
        1:       ra = 32'h7F00 + 32'($urandom_range(0, 11));
        2:       ra = 32'h7F10 + 32'($urandom_range(0, 11));
        3:       ra = $urandom;
        default: ra = 32'h7F00 + 32'($urandom_range(0, 31));
      endcase
      rv = modelVector(ra, $urandom, 4'($urandom), $urandom_range(1, TIMEOUT + 2), $urandom);
      runVector($sformatf("rnd%0d", n), rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_bridge_n.md
Name: sys_bridge_n

Overview:
- Parametrised CPU-to-peripheral bridge; successor to the fixed DM/Timer0/Timer1 combinational decoder.
- Sits between the CPU memory stage and N slaves: DM, timers and future devices.
- Decodes address windows and routes byte enables and write data. Registers the transaction and waits for a per-slave ready.
- Flags unmapped or timed-out accesses as bus errors, and registers slave interrupt lines into a HWInt vector.

Parameters:
- NSLV, 3: number of slaves.
- SLV_BASE, {32'h7F10,32'h7F00,32'h0}: packed NSLV×32 window base addresses; slave i uses slice [32i+31:32i].
- SLV_LIMIT, {32'h7F1B,32'h7F0B,32'h2FFF}: packed NSLV×32 inclusive window limits.
- TIMEOUT, 16: maximum ACCESS cycles to wait for ready; must be ≥2.
- TCW, 5: timeout counter width, $clog2(TIMEOUT)+1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  CPU access request; sampled only in IDLE.
- addr  in  32  CPU byte address.
- wdata  in  32  CPU write data.
- byteen  in  4  CPU byte enables; nonzero means write, 0 means read.
- busy  out  1  stall to CPU; high in ACCESS and RESP.
- rvalid  out  1  one-cycle completion pulse.
- rdata  out  32  read data; valid when rvalid=1.
- bus_err  out  1  qualifies rvalid: access failed.
- err_addr  out  32  address of the last failed access.
- sl_sel  out  NSLV  one-hot slave select.
- sl_addr  out  32  registered address, shared by all slaves.
- sl_wdata  out  32  registered write data, shared by all slaves.
- sl_byteen  out  NSLV*4  per-slave byte enables; zero unless that slave is selected.
- sl_rdata  in  NSLV*32  packed slave read data.
- sl_ready  in  NSLV  slave completes its access this cycle.
- irq_in  in  NSLV  slave interrupt levels.
- hwint  out  NSLV  registered interrupt vector to CP0.

Behaviour:
- Reset: async on reset_n=0.
  - FSM goes to IDLE.
  - All outputs and registers are 0: busy, rvalid, rdata, bus_err, err_addr, sl_sel, sl_addr, sl_wdata, sl_byteen, hwint and the counter.
  - Reset mid-transaction abandons the transaction; no rvalid is ever produced for it.
- Decode: slave i hits when SLV_BASE[i] ≤ addr ≤ SLV_LIMIT[i], unsigned compare. On overlapping windows the lowest index wins.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - req=0: stay in IDLE.
  - req=1 with a hit on slave k: latch addr, wdata, byteen and k; go to ACCESS; clear the counter.
  - req=1 with no hit: latch err_addr←addr; go to RESP with bus_err=1 and rdata=0. No slave is selected.
- ACCESS:
  - sl_sel[k]=1 and sl_byteen[k]=latched byteen; all other slaves see 0.
  - sl_ready[k]=1: capture sl_rdata[k] into rdata (also for writes); bus_err=0; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ready: err_addr←latched addr; bus_err=1; rdata=0; go to RESP.
  - sl_ready from unselected slaves is ignored.
- RESP: rvalid=1 for exactly one cycle; sl_sel=0; next state is IDLE.
- busy=1 in ACCESS and RESP. busy is combinational from state, so the CPU holds req and addr stable while stalled.
- req is ignored outside IDLE. A back-to-back req is accepted in the cycle after RESP.
- Latency: req at cycle t, with ready present in the first ACCESS cycle (t+1), gives rvalid at t+2.
- rdata and bus_err hold their values until the next RESP.
- hwint is a one-flop register of irq_in and updates every cycle, independent of the FSM.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the default DM/Timer0/Timer1 base/limit constants.
- One sub-module, addr_decode_n: combinational, takes addr, returns hit and a one-hot index with lowest-index priority.

Test Plan:
- Read DM: req, addr=0x100, byteen=0; sl_ready[0]=1 in the first ACCESS cycle, sl_rdata[0]=0xDEADBEEF → sl_sel=001 at t+1; rvalid=1, rdata=0xDEADBEEF, bus_err=0 at t+2.
- Byte write to Timer0: addr=0x7F04, byteen=4'b0010, wdata=0x12345678 → sl_byteen={4'h0,4'h2,4'h0}, sl_wdata=0x12345678, sl_sel=010.
- Unmapped access: addr=0x4000 → no sl_sel; rvalid=1, bus_err=1, rdata=0, err_addr=0x4000 at t+1.
- Timeout: Timer1 access, sl_ready held 0 → bus_err=1 and err_addr=0x7F10 on the rvalid pulse at cycle t+TIMEOUT+1 (t+17 for TIMEOUT=16).
- Wait states: ready asserted in the 3rd ACCESS cycle; req pulsed during busy → single rvalid at t+4; the extra req is ignored.
- Reset/interrupt: reset_n=0 mid-ACCESS → all outputs 0 immediately and no later rvalid; irq_in=3'b100 → hwint=3'b100 one cycle later.
